// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit controller: widths, funct3 access
// codes, RAM lane-select codes, FSM state encoding and request classification.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned halfword/word accesses
// become illegal instead of being silently aligned down).
package lsu_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    // funct3 access codes
    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;

    // ram_sel encodings
    localparam logic [2:0] SelByte = 3'b000;
    localparam logic [2:0] SelHalf = 3'b001;
    localparam logic [2:0] SelWord = 3'b010;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } lsu_state_e;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MisalignTrapEn = 1'b1;
`else
    localparam bit MisalignTrapEn = 1'b0;
`endif

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] a);
        return (f3 inside {3'b011, 3'b110, 3'b111}) || (we && f3[2]) ||
               (MisalignTrapEn && is_misaligned(f3, a));
    endfunction

    // Halfword/word addresses are forced onto their natural boundary.
    function automatic logic [XLEN-1:0] align_addr(input logic [2:0] f3,
                                                   input logic [XLEN-1:0] a);
        logic [XLEN-1:0] r;
        r = a;
        case (f3[1:0])
            2'b01:   r = {a[XLEN-1:1], 1'b0};
            2'b10:   r = {a[XLEN-1:2], 2'b00};
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: selects the byte/halfword lane from the RAM word and
// sign- or zero-extends it; word loads pass through unchanged.
module lsu_load_align
    import lsu_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select then extension by access type
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            Funct3Lb:  o_data = {{24{w_byte[7]}}, w_byte};
            Funct3Lh:  o_data = {{16{w_half[15]}}, w_half};
            Funct3Lbu: o_data = {24'b0, w_byte};
            Funct3Lhu: o_data = {16'b0, w_half};
            default:   o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time, performs a single
// RAM access cycle, then holds the response until it is consumed or flushed.
// Optional build macro: LSU_MISALIGN_TRAP_EN (see lsu_ctrl_pkg).
module lsu_ctrl
    import lsu_ctrl_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [XLEN-1:0] o_resp_rdata,
    output logic            o_resp_err,
    input  logic            i_flush,
    output logic            o_ram_ce,
    output logic            o_ram_we,
    output logic [XLEN-1:0] o_ram_addr,
    output logic [2:0]      o_ram_sel,
    output logic [XLEN-1:0] o_ram_wdata,
    input  logic [XLEN-1:0] i_ram_rdata
);

    lsu_state_e      r_state, w_state_d;
    logic            r_live;        // 0 until the first clock edge after reset
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;
    logic            r_ram_ce, r_ram_we;
    logic [XLEN-1:0] r_ram_addr, r_ram_wdata;
    logic [2:0]      r_ram_sel;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    logic            w_req_ready, w_accept, w_illegal, w_access;
    logic [XLEN-1:0] w_load_data;

    assign w_illegal = is_illegal(i_req_we, i_req_funct3, i_req_addr[1:0]);
    assign w_access  = w_accept & ~w_illegal;

    // Next-state and handshake decode
    always_comb begin
        w_state_d   = r_state;
        w_req_ready = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            StIdle: begin
                w_req_ready = r_live & ~i_flush;
                if (w_req_ready && i_req_valid) begin
                    w_accept  = 1'b1;
                    w_state_d = w_illegal ? StResp : StAccess;
                end
            end
            // A flushed access still completes; only the response is dropped.
            StAccess: w_state_d = i_flush ? StIdle : StResp;
            StResp:   if (i_flush || i_resp_ready) w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // State register and reset-release tracking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_live  <= 1'b1;
        end
    end

    // Request latches and RAM port registers; ce/we are high only in the access cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_ram_ce    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_sel   <= SelByte;
            r_ram_wdata <= '0;
        end else begin
            r_ram_ce <= w_access;
            r_ram_we <= w_access & i_req_we;
            if (w_accept) begin
                r_we     <= i_req_we;
                r_funct3 <= i_req_funct3;
                r_lane   <= i_req_addr[1:0];
            end
            if (w_access) begin
                r_ram_addr  <= align_addr(i_req_funct3, i_req_addr);
                r_ram_sel   <= {1'b0, i_req_funct3[1:0]};
                r_ram_wdata <= i_req_wdata;
            end
        end
    end

    lsu_load_align u_load_align (
        .i_rdata  (i_ram_rdata),
        .i_addr   (r_lane),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    // Response capture: error at accept time, data at the end of the access cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept && w_illegal) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end else if (r_state == StAccess) begin
            r_rdata <= r_we ? '0 : w_load_data;
            r_err   <= 1'b0;
        end
    end

    assign o_req_ready  = w_req_ready;
    assign o_resp_valid = (r_state == StResp);
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;
    assign o_ram_ce     = r_ram_ce;
    assign o_ram_we     = r_ram_we;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_sel    = r_ram_sel;
    assign o_ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: behavioural RAM, vector table with a response scoreboard,
// plus directed sequences for back-pressure, flush and reset corner cases.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        flush;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [2:0]  ram_sel;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .i_flush      (flush),
        .o_ram_ce     (ram_ce),
        .o_ram_we     (ram_we),
        .o_ram_addr   (ram_addr),
        .o_ram_sel    (ram_sel),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata)
    );

    // Behavioural data RAM: combinational read, byte-lane write on the clock edge
    logic [31:0] mem [64];
    assign ram_rdata = mem[ram_addr[7:2]];
    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            case (ram_sel)
                3'b000: mem[ram_addr[7:2]][{ram_addr[1:0], 3'b000} +: 8] <= ram_wdata[7:0];
                3'b001: mem[ram_addr[7:2]][{ram_addr[1], 4'b0000} +: 16] <= ram_wdata[15:0];
                default: mem[ram_addr[7:2]] <= ram_wdata;
            endcase
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vt[$];
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input logic err);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rdata = rd; v.exp_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output bit ok, output int tries);
        bit acc;
        ok = 1'b0;
        tries = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        while (tries < 20) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
            tries++;
        end
        req_valid = 1'b0;
        if (!ok) timeout("accept");
    endtask

    // Returns at the falling edge where resp_valid is first seen.
    task automatic wait_resp(input string name, output int lat, output int ce_cnt,
                             output logic we_seen, output bit got);
        lat = 0; ce_cnt = 0; we_seen = 1'b0; got = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (ram_ce) begin
                ce_cnt++;
                we_seen = ram_we;
            end
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout(name);
    endtask

    // Pops the scoreboard, compares, completes the handshake.
    task automatic take_resp(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            timeout({name, ".scoreboard_empty"});
        end else begin
            e = sb_q.pop_front();
            chk({name, ".rdata"}, resp_rdata, e.rdata);
            chk({name, ".err"}, {31'b0, resp_err}, {31'b0, e.err});
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        bit ok, got;
        int tries, lat, ce;
        logic wes;
        exp_t e;
        resp_ready = 1'b1;
        issue(v.we, v.f3, v.addr, v.wdata, ok, tries);
        if (!ok) return;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb_q.push_back(e);
        wait_resp(name, lat, ce, wes, got);
        if (!got) return;
        chk({name, ".latency"}, lat, v.exp_err ? 1 : 2);
        chk({name, ".ram_ce_cycles"}, ce, v.exp_err ? 0 : 1);
        if (!v.exp_err) chk({name, ".ram_we"}, {31'b0, wes}, {31'b0, v.we});
        take_resp(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, got;
        int tries, lat, ce;
        logic wes;
        exp_t e;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0; flush = 1'b0;

        vt.push_back(mk(1, Funct3Lw,  32'h10, 32'hDEADBEEF, 32'h0, 0));
        vt.push_back(mk(0, Funct3Lw,  32'h10, 32'h0, 32'hDEADBEEF, 0));
        vt.push_back(mk(1, Funct3Lb,  32'h13, 32'hAAAAAA80, 32'h0, 0));
        vt.push_back(mk(0, Funct3Lb,  32'h13, 32'h0, 32'hFFFFFF80, 0));
        vt.push_back(mk(0, Funct3Lbu, 32'h13, 32'h0, 32'h00000080, 0));
        vt.push_back(mk(0, Funct3Lw,  32'h10, 32'h0, 32'h80ADBEEF, 0));
        vt.push_back(mk(0, Funct3Lw,  32'h12, 32'h0, Trap ? 32'h0 : 32'h80ADBEEF, Trap));
        vt.push_back(mk(0, Funct3Lh,  32'h10, 32'h0, 32'hFFFFBEEF, 0));
        vt.push_back(mk(0, Funct3Lhu, 32'h12, 32'h0, 32'h000080AD, 0));
        vt.push_back(mk(0, Funct3Lh,  32'h12, 32'h0, 32'hFFFF80AD, 0));
        vt.push_back(mk(0, Funct3Lb,  32'h11, 32'h0, 32'hFFFFFFBE, 0));
        vt.push_back(mk(0, Funct3Lbu, 32'h10, 32'h0, 32'h000000EF, 0));
        vt.push_back(mk(0, Funct3Lh,  32'h11, 32'h0, Trap ? 32'h0 : 32'hFFFFBEEF, Trap));
        vt.push_back(mk(1, Funct3Lh,  32'h16, 32'hCAFE1234, 32'h0, 0));
        vt.push_back(mk(0, Funct3Lw,  32'h14, 32'h0, 32'h12340000, 0));
        vt.push_back(mk(0, 3'b011,    32'h10, 32'h0, 32'h0, 1));
        vt.push_back(mk(1, 3'b100,    32'h10, 32'h0, 32'h0, 1));
        vt.push_back(mk(0, Funct3Lw,  32'h10, 32'h0, 32'h80ADBEEF, 0));
        vt.push_back(mk(0, 3'b111,    32'h10, 32'h0, 32'h0, 1));
        vt.push_back(mk(1, Funct3Lw,  32'h19, 32'h55667788, 32'h0, Trap));
        vt.push_back(mk(0, Funct3Lw,  32'h18, 32'h0, Trap ? 32'h0 : 32'h55667788, 0));
        vt.push_back(mk(0, Funct3Lh,  32'h1A, 32'h0, Trap ? 32'h0 : 32'h00005566, 0));
        vt.push_back(mk(0, Funct3Lb,  32'h1B, 32'h0, Trap ? 32'h0 : 32'h00000055, 0));

        // Reset values and release timing
        #2;
        chk("rst.req_ready", {31'b0, req_ready}, 32'h0);
        chk("rst.resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst.resp_rdata", resp_rdata, 32'h0);
        chk("rst.resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst.ram_ctl", {29'b0, ram_ce, ram_we, 1'b0}, 32'h0);
        chk("rst.ram_addr", ram_addr, 32'h0);
        chk("rst.ram_sel", {29'b0, ram_sel}, 32'h0);
        chk("rst.ram_wdata", ram_wdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("rel.req_ready_before_edge", {31'b0, req_ready}, 32'h0);
        @(posedge clk); #1;
        chk("rel.req_ready_after_edge", {31'b0, req_ready}, 32'h1);

        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Back-pressure: response held for 5 cycles, next request accepted right after
        resp_ready = 1'b0;
        issue(0, Funct3Lw, 32'h10, 32'h0, ok, tries);
        e.rdata = 32'h80ADBEEF; e.err = 1'b0;
        sb_q.push_back(e);
        wait_resp("bp", lat, ce, wes, got);
        for (int i = 0; i < 5; i++) begin
            chk("bp.resp_valid", {31'b0, resp_valid}, 32'h1);
            chk("bp.resp_rdata", resp_rdata, 32'h80ADBEEF);
            chk("bp.req_ready", {31'b0, req_ready}, 32'h0);
            @(negedge clk);
        end
        take_resp("bp");
        issue(0, Funct3Lbu, 32'h13, 32'h0, ok, tries);
        chk("bp.accept_next_cycle", tries, 0);
        e.rdata = 32'h00000080; e.err = 1'b0;
        sb_q.push_back(e);
        wait_resp("bp2", lat, ce, wes, got);
        take_resp("bp2");

        // Flush during the access cycle of a store: store commits, no response
        issue(1, Funct3Lw, 32'h20, 32'h12345678, ok, tries);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_st.ram_ce", {31'b0, ram_ce}, 32'h1);
        chk("fl_st.ram_we", {31'b0, ram_we}, 32'h1);
        chk("fl_st.ram_addr", ram_addr, 32'h20);
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fl_st.no_resp", {31'b0, resp_valid}, 32'h0);
        end
        chk("fl_st.idle_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
        run_vec(mk(0, Funct3Lw, 32'h20, 32'h0, 32'h12345678, 0), "fl_st.readback");

        // Flush while a response is pending
        resp_ready = 1'b0;
        issue(0, Funct3Lw, 32'h14, 32'h0, ok, tries);
        wait_resp("fl_rsp", lat, ce, wes, got);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fl_rsp.resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("fl_rsp.req_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;

        // Flush in idle blocks acceptance
        flush = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = Funct3Lw; req_addr = 32'h10;
        @(negedge clk);
        chk("fl_idle.req_ready", {31'b0, req_ready}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fl_idle.ram_ce", {31'b0, ram_ce}, 32'h0);
        chk("fl_idle.resp_valid", {31'b0, resp_valid}, 32'h0);
        flush = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;

        // Reset during the access cycle forces ram_we low immediately
        resp_ready = 1'b1;
        issue(1, Funct3Lw, 32'h30, 32'hFFFFFFFF, ok, tries);
        #2 rst_n = 1'b0;
        #1 chk("rst_acc.ram_we", {31'b0, ram_we}, 32'h0);
        chk("rst_acc.ram_ce", {31'b0, ram_ce}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_acc.ready_after", {31'b0, req_ready}, 32'h1);

        // Reset while a response is pending
        resp_ready = 1'b0;
        issue(0, Funct3Lw, 32'h10, 32'h0, ok, tries);
        wait_resp("rst_rsp", lat, ce, wes, got);
        #2 rst_n = 1'b0;
        #1 chk("rst_rsp.resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_rsp.resp_rdata", resp_rdata, 32'h0);
        chk("rst_rsp.req_ready", {31'b0, req_ready}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("rst_rsp.ready_before_edge", {31'b0, req_ready}, 32'h0);
        @(posedge clk); #1;
        chk("rst_rsp.ready_after_edge", {31'b0, req_ready}, 32'h1);
        chk("rst_rsp.idle_no_resp", {31'b0, resp_valid}, 32'h0);
        run_vec(mk(0, Funct3Lw, 32'h10, 32'h0, 32'h80ADBEEF, 0), "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
